// File: rtl/pc_pkg.sv
// Shared types and defaults for the program counter slice.
package pc_pkg;

   localparam int XLEN = 32;

   typedef logic [XLEN-1:0] addr_t;

   localparam addr_t       DEFAULT_RESET_VECTOR = 32'h0000_0000;
   localparam int unsigned DEFAULT_PC_INCR      = 4;

endpackage : pc_pkg

// File: rtl/pc_if.sv
// Control/data bundle between the decode/hazard logic (master) and the PC (slave).
interface pc_if;
   import pc_pkg::*;

   logic  writeEnable;
   logic  hazardDetected;
   logic  PCSrcD;
   addr_t PCBranchD;
   logic  loadEn;
   addr_t inpPC;
   addr_t outPC;
   addr_t newPC;
   logic  misalignFault;

   modport master (
      output writeEnable, hazardDetected, PCSrcD, PCBranchD, loadEn, inpPC,
      input  outPC, newPC, misalignFault
   );

   modport slave (
      input  writeEnable, hazardDetected, PCSrcD, PCBranchD, loadEn, inpPC,
      output outPC, newPC, misalignFault
   );

endinterface : pc_if

// File: rtl/pc_next_logic.sv
// Next-PC candidate, redirect mux and target alignment check.
// Alignment checking is compiled in only when PC_ALIGN_CHECK_EN is defined.
module pc_next_logic
   import pc_pkg::*;
#(
   parameter int unsigned PC_INCR = DEFAULT_PC_INCR
) (
   input  addr_t outPC,
   input  logic  PCSrcD,
   input  addr_t PCBranchD,
   input  logic  loadEn,
   input  addr_t inpPC,
   output addr_t newPC,
   output addr_t nextValue,
   output logic  targetMisaligned
);

   localparam addr_t INCR = addr_t'(PC_INCR);

   addr_t seqPC;

   always_comb begin
      seqPC     = outPC + INCR;
      newPC     = PCSrcD ? PCBranchD : seqPC;
      nextValue = loadEn ? inpPC : newPC;
   end

   // Only explicit targets are checked; the sequential path stays aligned by construction.
`ifdef PC_ALIGN_CHECK_EN
   always_comb begin
      if (loadEn) targetMisaligned = |inpPC[1:0];
      else        targetMisaligned = PCSrcD & (|PCBranchD[1:0]);
   end
`else
   assign targetMisaligned = 1'b0;
`endif

endmodule : pc_next_logic

// File: rtl/program_counter.sv
// PC register with redirect > update > hold priority and a one-cycle misalign pulse
// (pulse only possible when built with PC_ALIGN_CHECK_EN).
module program_counter
   import pc_pkg::*;
#(
   parameter addr_t       RESET_VECTOR = DEFAULT_RESET_VECTOR,
   parameter int unsigned PC_INCR      = DEFAULT_PC_INCR
) (
   input logic clk,
   input logic reset,
   pc_if.slave bus
);

   addr_t pcReg;
   addr_t newPC;
   addr_t nextValue;
   logic  targetMisaligned;
   logic  update;
   logic  fault;
   logic  faultReg;

   pc_next_logic #(
      .PC_INCR (PC_INCR)
   ) uNextLogic (
      .outPC            (pcReg),
      .PCSrcD           (bus.PCSrcD),
      .PCBranchD        (bus.PCBranchD),
      .loadEn           (bus.loadEn),
      .inpPC            (bus.inpPC),
      .newPC            (newPC),
      .nextValue        (nextValue),
      .targetMisaligned (targetMisaligned)
   );

   // A redirect is never stalled, so loadEn alone qualifies an update.
   always_comb begin
      update = bus.loadEn | (bus.writeEnable & ~bus.hazardDetected);
      fault  = update & targetMisaligned;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pcReg    <= RESET_VECTOR;
         faultReg <= 1'b0;
      end else begin
         faultReg <= fault;
         if (update && !fault) pcReg <= nextValue;
      end
   end

   assign bus.outPC         = pcReg;
   assign bus.newPC         = newPC;
   assign bus.misalignFault = faultReg;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter (RESET_VECTOR=0, PC_INCR=4).
module tb_program_counter;
   import pc_pkg::*;

   logic clk;
   logic reset;
   int   testCount;
   int   failCount;

   pc_if bus();

   program_counter #(
      .RESET_VECTOR (32'h0000_0000),
      .PC_INCR      (4)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      testCount = 0;
      failCount = 0;
      reset              = 1'b0;
      bus.writeEnable    = 1'b0;
      bus.hazardDetected = 1'b0;
      bus.PCSrcD         = 1'b0;
      bus.PCBranchD      = '0;
      bus.loadEn         = 1'b0;
      bus.inpPC          = '0;

      #3;
      check("reset_outPC", bus.outPC, 32'h0);
      check("reset_fault", {31'b0, bus.misalignFault}, 32'h0);
      check("reset_newPC", bus.newPC, 32'h4);

      // Release between edges, then sequential stepping
      #9;
      bus.writeEnable = 1'b1;
      reset = 1'b1;
      step(); check("seq_1", bus.outPC, 32'h4);
      step(); check("seq_2", bus.outPC, 32'h8);
      step(); check("seq_3", bus.outPC, 32'hC);

      // Asynchronous reset between edges, held across an edge
      #2; reset = 1'b0;
      #1; check("async_reset_now", bus.outPC, 32'h0);
      step(); check("reset_held_edge", bus.outPC, 32'h0);
      #3; reset = 1'b1;
      step(); check("first_update", bus.outPC, 32'h4);
      step(); check("second_update", bus.outPC, 32'h8);

      // Branch
      bus.PCSrcD    = 1'b1;
      bus.PCBranchD = 32'h40;
      #1; check("branch_newPC", bus.newPC, 32'h40);
      step(); check("branch_taken", bus.outPC, 32'h40);

      // Stall via hazard
      bus.PCSrcD         = 1'b0;
      bus.hazardDetected = 1'b1;
      step(); step();
      check("hazard_hold", bus.outPC, 32'h40);
      check("hazard_newPC", bus.newPC, 32'h44);

      // Stall via writeEnable=0
      bus.hazardDetected = 1'b0;
      bus.writeEnable    = 1'b0;
      step(); step();
      check("wen0_hold", bus.outPC, 32'h40);
      check("wen0_newPC", bus.newPC, 32'h44);

      // Branch during stall is dropped
      bus.writeEnable    = 1'b1;
      bus.hazardDetected = 1'b1;
      bus.PCSrcD         = 1'b1;
      bus.PCBranchD      = 32'h80;
      #1; check("stall_branch_newPC", bus.newPC, 32'h80);
      step(); check("stall_branch_hold", bus.outPC, 32'h40);
      bus.hazardDetected = 1'b0;
      bus.PCSrcD         = 1'b0;
      step(); check("branch_not_kept", bus.outPC, 32'h44);

      // Redirect overrides stall, writeEnable=0 and a pending branch
      bus.loadEn         = 1'b1;
      bus.inpPC          = 32'h100;
      bus.hazardDetected = 1'b1;
      bus.writeEnable    = 1'b0;
      bus.PCSrcD         = 1'b1;
      bus.PCBranchD      = 32'h200;
      step(); check("redirect", bus.outPC, 32'h100);
      bus.loadEn         = 1'b0;
      bus.hazardDetected = 1'b0;
      bus.writeEnable    = 1'b1;
      bus.PCSrcD         = 1'b0;
      step(); check("after_redirect", bus.outPC, 32'h104);

      // Wrap
      bus.loadEn = 1'b1;
      bus.inpPC  = 32'hFFFF_FFFC;
      step(); check("wrap_load", bus.outPC, 32'hFFFF_FFFC);
      bus.loadEn = 1'b0;
      #1; check("wrap_newPC", bus.newPC, 32'h0);
      step(); check("wrap_outPC", bus.outPC, 32'h0);

      // Misaligned branch target
      bus.PCSrcD    = 1'b1;
      bus.PCBranchD = 32'h42;
      step();
`ifdef PC_ALIGN_CHECK_EN
      check("misalign_hold", bus.outPC, 32'h0);
      check("misalign_pulse", {31'b0, bus.misalignFault}, 32'h1);
      bus.PCSrcD = 1'b0;
      step();
      check("misalign_clear", {31'b0, bus.misalignFault}, 32'h0);
      check("misalign_resume", bus.outPC, 32'h4);
`else
      check("unaligned_load", bus.outPC, 32'h42);
      check("fault_tied_low", {31'b0, bus.misalignFault}, 32'h0);
      bus.PCSrcD = 1'b0;
      step();
      check("unaligned_seq", bus.outPC, 32'h46);
      check("fault_still_low", {31'b0, bus.misalignFault}, 32'h0);
`endif

      // Asynchronous reset mid-stall with a branch presented
      bus.hazardDetected = 1'b1;
      bus.PCSrcD         = 1'b1;
      bus.PCBranchD      = 32'h80;
      #2; reset = 1'b0;
      #1; check("midstall_reset", bus.outPC, 32'h0);
      check("midstall_fault", {31'b0, bus.misalignFault}, 32'h0);
      #3; reset = 1'b1;
      bus.hazardDetected = 1'b0;
      step(); check("post_reset_branch", bus.outPC, 32'h80);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule : tb_program_counter
